instr_fetch: RTL and testbench

- Fetch stage directly upstream of the register file and decode.
- Holds the PC and issues word reads to a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned instructions in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Drives the register-address fields rs1/rs2/rd and accepts PC redirects for branches and jumps.

---
 rtl/instr_fetch.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// instr_fetch: fetch stage feeding register file and decode.
//   Holds the PC, issues word reads to a 1-cycle-latency synchronous ROM and
//   buffers returned words in a 2-entry FIFO presented with valid/ready.
//   Redirects flush the FIFO and restart fetch at the new address.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    ROM read request and word-aligned byte address
//   imem_rdata            ROM data, valid the cycle after imem_req
//   redirect_valid/_pc    taken branch/jump, restart address (bits [1:0] ignored)
//   out_valid/out_ready   head handshake toward decode
//   out_instr/out_pc      head instruction and its PC (0 when empty)
//   rs1/rs2/rd            register-address fields sliced from out_instr
// Optional feature (macro FETCH_STATS_EN):
//   stat_fetched          saturating count of instructions handed to decode
//   stat_flushed          saturating count of entries/responses discarded by redirects
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_flushed
`endif
);

  localparam int unsigned IW = 32;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [IW-1:0]         instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_pc, w_nxt_pc;
  logic                  r_inflight, w_nxt_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc, w_nxt_inflight_pc;
  logic                  r_kill, w_nxt_kill;
  logic [CW-1:0]         r_count, w_nxt_count;
  entry_t                r_ent0, r_ent1, w_nxt_ent0, w_nxt_ent1;

  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_credit;
  logic [CW-1:0]         w_cnt_after_pop;
  entry_t                w_new_ent;

  // Handshake and credit: count + inflight - pop must stay below FIFO depth.
  always_comb begin
    w_out_valid     = (r_count != '0);
    w_pop           = w_out_valid & out_ready;
    w_credit        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    w_issue         = rst_n & ~redirect_valid & (w_credit < 3'd2);
    w_push          = r_inflight & ~r_kill & ~redirect_valid;
    w_cnt_after_pop = r_count - CW'(w_pop);
    w_new_ent.instr = imem_rdata;
    w_new_ent.pc    = r_inflight_pc;
  end

  // Next-state: redirect overrides everything; otherwise issue, shift-pop, push.
  always_comb begin
    w_nxt_pc          = r_pc;
    w_nxt_inflight    = r_inflight;
    w_nxt_inflight_pc = r_inflight_pc;
    w_nxt_kill        = r_kill;
    w_nxt_count       = r_count;
    w_nxt_ent0        = r_ent0;
    w_nxt_ent1        = r_ent1;
    if (redirect_valid) begin
      w_nxt_pc       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      w_nxt_kill     = r_inflight;
      w_nxt_inflight = 1'b0;
      w_nxt_count    = '0;
    end else begin
      w_nxt_kill     = 1'b0;
      w_nxt_inflight = w_issue;
      if (w_issue) begin
        w_nxt_inflight_pc = r_pc;
        w_nxt_pc          = r_pc + ADDR_WIDTH'(4);
      end
      // Head always lives in entry 0; a pop shifts entry 1 forward.
      if (w_pop) begin
        w_nxt_ent0 = r_ent1;
      end
      if (w_push) begin
        if (w_cnt_after_pop == '0) begin
          w_nxt_ent0 = w_new_ent;
        end else begin
          w_nxt_ent1 = w_new_ent;
        end
      end
      w_nxt_count = w_cnt_after_pop + CW'(w_push);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
      r_count       <= '0;
      r_ent0        <= '0;
      r_ent1        <= '0;
    end else begin
      r_pc          <= w_nxt_pc;
      r_inflight    <= w_nxt_inflight;
      r_inflight_pc <= w_nxt_inflight_pc;
      r_kill        <= w_nxt_kill;
      r_count       <= w_nxt_count;
      r_ent0        <= w_nxt_ent0;
      r_ent1        <= w_nxt_ent1;
    end
  end

  // Outputs: head fields forced to zero when the FIFO is empty.
  always_comb begin
    imem_req  = w_issue;
    imem_addr = r_pc;
    out_valid = w_out_valid;
    out_instr = w_out_valid ? r_ent0.instr : '0;
    out_pc    = w_out_valid ? r_ent0.pc    : '0;
    rs1       = out_instr[19:15];
    rs2       = out_instr[24:20];
    rd        = out_instr[11:7];
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;
  logic [1:0]  w_flush_inc;
  logic [32:0] w_flush_sum;

  // Discards on redirect: entries left after this cycle's pop plus the dropped response.
  always_comb begin
    w_flush_inc = (r_count - CW'(w_pop)) + 2'(r_inflight);
    w_flush_sum = 33'(r_stat_flushed) + 33'(w_flush_inc);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_pop && (r_stat_fetched != 32'hFFFF_FFFF)) begin
        r_stat_fetched <= r_stat_fetched + 32'd1;
      end
      if (redirect_valid) begin
        r_stat_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
      end
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// Directed bench for instr_fetch: streaming, wrap, stall, mid-stream reset,
// redirects (full FIFO, in-flight drop, back-to-back) and register fields.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  rs1, rs2, rd;

  // Second instance with a PC close to the top of the address space.
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic [4:0]  w_rs1, w_rs2, w_rd;

  int n_vec;
  int n_err;

  instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_instr(w_out_instr), .out_pc(w_out_pc),
    .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word i = 0x1000_0000 + i, except an add a0,a0,a1 at 0x80.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_0080) return 32'h00B5_0533;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  initial begin
    imem_rdata   = '0;
    w_imem_rdata = '0;
  end

  always @(posedge clk) begin
    if (imem_req)   imem_rdata   <= rom(imem_addr);
    if (w_imem_req) w_imem_rdata <= rom(w_imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc(); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_instr", out_instr,      32'h0);
    check("rst_pc",    out_pc,         32'h0);
    check("rst_rs1",   32'(rs1),       32'd0);
    check("rst_wvalid", 32'(w_out_valid), 32'd0);

    // Streaming with out_ready held high.
    cyc(); rst_n = 1'b1; #1;
    check("c0_req",   32'(imem_req), 32'd1);
    check("c0_addr",  imem_addr,     32'h0);
    check("c0_waddr", w_imem_addr,   32'hFFFF_FFF8);
    check("c0_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("c1_valid", 32'(out_valid), 32'd0);
    check("c1_addr",  imem_addr,      32'h4);
    cyc(); #1;
    check("c2_valid",  32'(out_valid), 32'd1);
    check("c2_pc",     out_pc,         32'h0);
    check("c2_instr",  out_instr,      32'h1000_0000);
    check("c2_wpc",    w_out_pc,       32'hFFFF_FFF8);
    check("c2_winstr", w_out_instr,    32'h4FFF_FFFE);
    cyc(); #1;
    check("c3_pc",  out_pc,    32'h4);
    check("c3_ins", out_instr, 32'h1000_0001);
    check("c3_wpc", w_out_pc,  32'hFFFF_FFFC);
    cyc(); #1;
    check("c4_pc",     out_pc,      32'h8);
    check("c4_wpc",    w_out_pc,    32'h0);
    check("c4_winstr", w_out_instr, 32'h1000_0000);

    // Fill the FIFO, then pulse reset with count at 2.
    cyc(); out_ready = 1'b0; #1;
    check("c5_pc",  out_pc,          32'hC);
    check("c5_req", 32'(imem_req),   32'd0);
    cyc(); #1;
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_req",   32'(imem_req),  32'd0);
    check("full_pc",    out_pc,         32'hC);
    rst_n = 1'b0; #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_req",   32'(imem_req),  32'd0);
    check("arst_instr", out_instr,      32'h0);

    // Restart with decode stalled from the start.
    cyc(); rst_n = 1'b1; #1;
    check("r0_req",  32'(imem_req), 32'd1);
    check("r0_addr", imem_addr,     32'h0);
    cyc(); #1;
    check("r1_req",   32'(imem_req),  32'd1);
    check("r1_addr",  imem_addr,      32'h4);
    check("r1_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("r2_valid", 32'(out_valid), 32'd1);
    check("r2_pc",    out_pc,         32'h0);
    check("r2_req",   32'(imem_req),  32'd0);
    for (int i = 3; i <= 7; i++) begin
      cyc(); #1;
      check("stall_req",   32'(imem_req), 32'd0);
      check("stall_pc",    out_pc,        32'h0);
      check("stall_instr", out_instr,     32'h1000_0000);
    end
    cyc(); out_ready = 1'b1; #1;
    check("rel_pc",   out_pc,        32'h0);
    check("rel_req",  32'(imem_req), 32'd1);
    check("rel_addr", imem_addr,     32'h8);
    cyc(); #1;
    check("rel1_pc", out_pc, 32'h4);
    cyc(); out_ready = 1'b0; #1;
    check("rel2_pc", out_pc, 32'h8);

    // Redirect with the FIFO full.
    cyc(); #1;
    check("pre_rd_req", 32'(imem_req), 32'd0);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; #1;
    check("rd_req",   32'(imem_req),  32'd0);
    check("rd_valid", 32'(out_valid), 32'd1);
    check("rd_pc",    out_pc,         32'h8);
    cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    check("rd1_valid", 32'(out_valid), 32'd0);
    check("rd1_req",   32'(imem_req),  32'd1);
    check("rd1_addr",  imem_addr,      32'h40);
    cyc(); #1;
    check("rd2_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("rd3_valid", 32'(out_valid), 32'd1);
    check("rd3_pc",    out_pc,         32'h40);
    check("rd3_instr", out_instr,      32'h1000_0010);

    // Redirect while streaming: head handed off, in-flight 0x48 dropped.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; #1;
    check("rs_pop_pc", out_pc,        32'h44);
    check("rs_req",    32'(imem_req), 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    check("rs1_valid", 32'(out_valid), 32'd0);
    check("rs1_addr",  imem_addr,      32'h80);
    cyc(); #1;
    check("rs2_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("rs3_pc",    out_pc,     32'h80);
    check("rs3_instr", out_instr,  32'h00B5_0533);
    check("rs3_rs1",   32'(rs1),   32'd10);
    check("rs3_rs2",   32'(rs2),   32'd11);
    check("rs3_rd",    32'(rd),    32'd10);
    cyc(); #1;
    check("rs4_pc",    out_pc,    32'h84);
    check("rs4_instr", out_instr, 32'h1000_0021);

    // Back-to-back redirects: the second wins, low bits ignored.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    check("bb0_req", 32'(imem_req), 32'd0);
    cyc(); redirect_pc = 32'h0000_0205; #1;
    check("bb1_req",   32'(imem_req),  32'd0);
    check("bb1_valid", 32'(out_valid), 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    check("bb2_req",  32'(imem_req), 32'd1);
    check("bb2_addr", imem_addr,     32'h204);
    cyc(); cyc(); #1;
    check("bb4_valid", 32'(out_valid), 32'd1);
    check("bb4_pc",    out_pc,         32'h204);
    check("bb4_instr", out_instr,      32'h1000_0081);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
